// File: rtl/connect4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : connect4_pkg                                               |
// | Purpose   : Shared types and constants for the 4x4 Connect-4 column    |
// |             selection controller: FSM state encoding, game-status      |
// |             codes and board geometry.                                  |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
package connect4_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  // Column request value meaning "no request"
  localparam logic [2:0] NO_COL = 3'b111;

  // Game-status codes exchanged with the win checker
  localparam logic [1:0] PLAYING = 2'b00;
  localparam logic [1:0] P1_WIN  = 2'b01;
  localparam logic [1:0] P2_WIN  = 2'b10;
  localparam logic [1:0] DRAW    = 2'b11;

  typedef enum logic [1:0] {
    WAIT  = 2'b00,
    CHECK = 2'b01,
    PLACE = 2'b10,
    OVER  = 2'b11
  } state_e;

endpackage
`default_nettype wire

// File: rtl/connect4_col_height.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : connect4_col_height                                        |
// | Purpose   : Combinational column probe. For the selected column it     |
// |             returns the lowest empty row and whether the column is     |
// |             full (top cell occupied).                                  |
// | Ports     : gameboard_i [15:0] occupancy, bit r*4+c = (row r, col c)   |
// |             col_i       [1:0]  column to probe                         |
// |             row_o       [1:0]  lowest empty row (3 when only top free) |
// |             full_o             top cell of the column occupied         |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module connect4_col_height
  import connect4_pkg::*;
(
  input  logic [15:0] gameboard_i,
  input  logic [1:0]  col_i,
  output logic [1:0]  row_o,
  output logic        full_o
);

  // Column cells gathered bottom (bit 0) to top (bit 3)
  logic [ROWS-1:0] w_colbits;

  always_comb begin
    w_colbits = '0;
    case (col_i)
      2'd0:    w_colbits = {gameboard_i[12], gameboard_i[8], gameboard_i[4], gameboard_i[0]};
      2'd1:    w_colbits = {gameboard_i[13], gameboard_i[9], gameboard_i[5], gameboard_i[1]};
      2'd2:    w_colbits = {gameboard_i[14], gameboard_i[10], gameboard_i[6], gameboard_i[2]};
      default: w_colbits = {gameboard_i[15], gameboard_i[11], gameboard_i[7], gameboard_i[3]};
    endcase
  end

  always_comb begin
    if (!w_colbits[0])      row_o = 2'd0;
    else if (!w_colbits[1]) row_o = 2'd1;
    else if (!w_colbits[2]) row_o = 2'd2;
    else                    row_o = 2'd3;
  end

  assign full_o = w_colbits[ROWS-1];

endmodule
`default_nettype wire

// File: rtl/connect4_colsel_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : connect4_colsel_fsm                                        |
// | Purpose   : Column-selection and piece-drop controller for a 4x4       |
// |             Connect-4 game. Validates a column request, drops the      |
// |             current player's piece into the lowest empty cell and      |
// |             alternates turns. Freezes once the game is over.           |
// | Ports     : clk, reset (async, active-high)                            |
// |             in_column[2:0]         0..3 column, 3'b111 none, 4..6 bad  |
// |             in_game_status[1:0]    status from win checker             |
// |             out_gameboard[15:0]    occupancy, row 0 = bottom           |
// |             out_players_cells[15:0] owner, 1 = P2                      |
// |             out_game_status[1:0]   registered status                   |
// |             current_state[1:0]     FSM state code                      |
// |             throw_again            last request rejected               |
// |             oinvalid_column        one-cycle rejection pulse           |
// |             playerTurn             0 = P1 to move, 1 = P2              |
// | Options   : CONNECT4_DRAW_DETECT_EN - full board in WAIT forces DRAW   |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module connect4_colsel_fsm
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  in_column,
  input  logic [1:0]  in_game_status,
  output logic [15:0] out_gameboard,
  output logic [15:0] out_players_cells,
  output logic [1:0]  out_game_status,
  output logic [1:0]  current_state,
  output logic        throw_again,
  output logic        oinvalid_column,
  output logic        playerTurn
);

  state_e      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic        armed_q, armed_d;
  logic [15:0] board_q, board_d;
  logic [15:0] cells_q, cells_d;
  logic [1:0]  status_q, status_d;
  logic        throw_q, throw_d;
  logic        inv_q, inv_d;
  logic        turn_q, turn_d;

  logic [1:0]  w_row;
  logic        w_full;
  logic [3:0]  w_idx;

  connect4_col_height u_col_height (
    .gameboard_i (board_q),
    .col_i       (col_q[1:0]),
    .row_o       (w_row),
    .full_o      (w_full)
  );

  // Cell index r*4+col
  assign w_idx = {w_row, col_q[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT;
      col_q    <= '0;
      armed_q  <= 1'b1;
      board_q  <= '0;
      cells_q  <= '0;
      status_q <= PLAYING;
      throw_q  <= 1'b0;
      inv_q    <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      armed_q  <= armed_d;
      board_q  <= board_d;
      cells_q  <= cells_d;
      status_q <= status_d;
      throw_q  <= throw_d;
      inv_q    <= inv_d;
      turn_q   <= turn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    armed_d  = armed_q;
    board_d  = board_q;
    cells_d  = cells_q;
    status_d = status_q;
    throw_d  = throw_q;
    inv_d    = 1'b0;
    turn_d   = turn_q;

    if (state_q != OVER) status_d = in_game_status;

    case (state_q)
      WAIT: begin
        if (in_game_status != PLAYING) begin
          state_d = OVER;
`ifdef CONNECT4_DRAW_DETECT_EN
        end else if (board_q == 16'hFFFF) begin
          status_d = DRAW;
          state_d  = OVER;
`endif
        end else if (armed_q && (in_column != NO_COL)) begin
          col_d   = in_column;
          armed_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // col_q[2] set means column 4..6, outside the board
        if (col_q[2] || w_full) begin
          inv_d   = 1'b1;
          throw_d = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        board_d[w_idx] = 1'b1;
        cells_d[w_idx] = turn_q;
        turn_d         = ~turn_q;
        throw_d        = 1'b0;
        state_d        = WAIT;
      end
      OVER: begin
        state_d = OVER;
      end
      default: state_d = WAIT;
    endcase

    // Releasing the request re-arms capture, so a held request drops once
    if (in_column == NO_COL) armed_d = 1'b1;
  end

  assign out_gameboard     = board_q;
  assign out_players_cells = cells_q;
  assign out_game_status   = status_q;
  assign current_state     = state_q;
  assign throw_again       = throw_q;
  assign oinvalid_column   = inv_q;
  assign playerTurn        = turn_q;

endmodule
`default_nettype wire

// File: tb/tb_connect4_colsel_fsm.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_connect4_colsel_fsm                                     |
// | Purpose   : Self-checking bench for connect4_colsel_fsm. A board-level |
// |             game model predicts every output each cycle; directed     |
// |             sequences pin the model with literal expectations, then    |
// |             randomized requests, statuses and resets follow.           |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module tb_connect4_colsel_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_column = 3'b111;
  logic [1:0]  in_game_status = 2'b00;
  logic [15:0] out_gameboard;
  logic [15:0] out_players_cells;
  logic [1:0]  out_game_status;
  logic [1:0]  current_state;
  logic        throw_again;
  logic        oinvalid_column;
  logic        playerTurn;

  connect4_colsel_fsm dut (
    .clk               (clk),
    .reset             (reset),
    .in_column         (in_column),
    .in_game_status    (in_game_status),
    .out_gameboard     (out_gameboard),
    .out_players_cells (out_players_cells),
    .out_game_status   (out_game_status),
    .current_state     (current_state),
    .throw_again       (throw_again),
    .oinvalid_column   (oinvalid_column),
    .playerTurn        (playerTurn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- game model ----------------
  // occ/own indexed [row][col]; a request goes through a two-edge
  // pipeline (validate, then drop) tracked by m_phase.
  bit   occ [4][4];
  bit   own [4][4];
  bit   m_turn, m_throw, m_inv, m_over, m_armed;
  int   m_phase;
  int   m_col;
  logic [1:0] m_status;

  function automatic logic [15:0] pack_occ();
    logic [15:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (occ[r][c]) v = v | (16'd1 << (r*4 + c));
    return v;
  endfunction

  function automatic logic [15:0] pack_own();
    logic [15:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (own[r][c]) v = v | (16'd1 << (r*4 + c));
    return v;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_over) return 2'b11;
    return 2'(m_phase);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        occ[r][c] = 1'b0;
        own[r][c] = 1'b0;
      end
    m_turn = 0; m_throw = 0; m_inv = 0; m_over = 0; m_armed = 1;
    m_phase = 0; m_col = 0; m_status = 2'b00;
  endtask

  task automatic model_step(input logic [2:0] ic, input logic [1:0] is);
    bit  was_over = m_over;
    bit  draw_now = 0;
    int  h;
    m_inv = 0;
    if (m_phase == 1) begin
      if (m_col > 3) begin
        m_inv = 1; m_throw = 1; m_phase = 0;
      end else if (occ[3][m_col]) begin
        m_inv = 1; m_throw = 1; m_phase = 0;
      end else begin
        m_phase = 2;
      end
    end else if (m_phase == 2) begin
      h = 0;
      while (h < 4 && occ[h][m_col]) h++;
      occ[h][m_col] = 1;
      own[h][m_col] = m_turn;
      m_turn  = !m_turn;
      m_throw = 0;
      m_phase = 0;
    end else if (!m_over) begin
      if (is != 2'b00) begin
        m_over = 1;
`ifdef CONNECT4_DRAW_DETECT_EN
      end else if (pack_occ() == 16'hFFFF) begin
        m_over = 1; draw_now = 1;
`endif
      end else if (m_armed && ic != 3'b111) begin
        m_col = int'(ic); m_armed = 0; m_phase = 1;
      end
    end
    if (ic == 3'b111) m_armed = 1;
    if (!was_over) m_status = draw_now ? 2'b11 : is;
  endtask

  initial model_reset();

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step(in_column, in_game_status);
  end

  // Per-cycle comparison away from the active edge
  bit compare_en = 0;
  always @(negedge clk) begin
    if (compare_en) begin
      chk("gameboard", 32'(out_gameboard), 32'(pack_occ()));
      chk("players",   32'(out_players_cells), 32'(pack_own()));
      chk("status",    32'(out_game_status), 32'(m_status));
      chk("state",     32'(current_state), 32'(exp_state()));
      chk("throw",     32'(throw_again), 32'(m_throw));
      chk("invalid",   32'(oinvalid_column), 32'(m_inv));
      chk("turn",      32'(playerTurn), 32'(m_turn));
    end
  end

  // ---------------- directed helpers ----------------
  int inv_seen;

  // Present a column for one edge, release, and wait until the drop has landed
  task automatic req(input logic [2:0] col);
    inv_seen = 0;
    @(negedge clk) in_column = col;
    @(negedge clk) in_column = 3'b111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (oinvalid_column) inv_seen++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    in_column = 3'b111; in_game_status = 2'b00;
    @(negedge clk) reset = 1'b0;
  endtask

  int over_cycles;
  int hold;

  initial begin
    @(negedge clk);
    @(negedge clk);
    compare_en = 1;
    chk("rst_board", 32'(out_gameboard), 32'h0);
    chk("rst_state", 32'(current_state), 32'h0);
    chk("rst_turn",  32'(playerTurn), 32'h0);
    reset = 1'b0;

    // Basic drops and stacking
    req(3'd0);
    chk("p1c0_board", 32'(out_gameboard), 32'h0001);
    chk("p1c0_cells", 32'(out_players_cells), 32'h0000);
    chk("p1c0_turn",  32'(playerTurn), 32'h1);
    chk("p1c0_state", 32'(current_state), 32'h0);
    req(3'd0);
    chk("p2c0_board", 32'(out_gameboard), 32'h0011);
    chk("p2c0_cells", 32'(out_players_cells), 32'h0010);
    chk("p2c0_turn",  32'(playerTurn), 32'h0);
    req(3'd2);
    req(3'd3);
    chk("c23_board", 32'(out_gameboard), 32'h001D);
    chk("c23_cells", 32'(out_players_cells), 32'h0018);

    // Invalid column
    req(3'd5);
    chk("bad_pulse", 32'(inv_seen), 32'd1);
    chk("bad_throw", 32'(throw_again), 32'h1);
    chk("bad_board", 32'(out_gameboard), 32'h001D);
    chk("bad_turn",  32'(playerTurn), 32'h0);
    req(3'd1);
    chk("ok_throw",  32'(throw_again), 32'h0);
    chk("ok_board",  32'(out_gameboard), 32'h001F);

    // Fill column 1, fifth request rejected
    do_reset();
    for (int i = 0; i < 4; i++) req(3'd1);
    chk("fill_board", 32'(out_gameboard), 32'h2222);
    chk("fill_cells", 32'(out_players_cells), 32'h2020);
    req(3'd1);
    chk("full_pulse", 32'(inv_seen), 32'd1);
    chk("full_throw", 32'(throw_again), 32'h1);
    chk("full_board", 32'(out_gameboard), 32'h2222);

    // Held request drops once
    @(negedge clk) in_column = 3'd0;
    repeat (5) @(negedge clk);
    in_column = 3'b111;
    repeat (2) @(negedge clk);
    chk("hold_board", 32'(out_gameboard), 32'h2223);
    chk("hold_cells", 32'(out_players_cells), 32'h2020);
    chk("hold_turn",  32'(playerTurn), 32'h1);

    // Game over freezes everything
    @(negedge clk) in_game_status = 2'b01;
    @(negedge clk);
    chk("over_state",  32'(current_state), 32'h3);
    chk("over_status", 32'(out_game_status), 32'h1);
    in_game_status = 2'b00;
    req(3'd2);
    chk("over_board",  32'(out_gameboard), 32'h2223);
    chk("over_hold",   32'(out_game_status), 32'h1);

    // Asynchronous reset in the middle of a request
    do_reset();
    req(3'd0);
    @(negedge clk) in_column = 3'd1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_board", 32'(out_gameboard), 32'h0);
    chk("arst_state", 32'(current_state), 32'h0);
    chk("arst_turn",  32'(playerTurn), 32'h0);
    @(negedge clk) reset = 1'b0;
    in_column = 3'b111;

    // Randomized play
    over_cycles = 0;
    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 5) in_column = 3'b111;
        else                          in_column = 3'($urandom_range(0, 6));
        hold = $urandom_range(1, 3);
      end
      hold--;
      if ($urandom_range(0, 299) == 0) in_game_status = 2'($urandom_range(1, 3));
      over_cycles = m_over ? over_cycles + 1 : 0;
      if (over_cycles > 6 || $urandom_range(0, 799) == 0) begin
        #($urandom_range(1, 4)) reset = 1'b1;
        #1;
        chk("rnd_arst_board", 32'(out_gameboard), 32'h0);
        chk("rnd_arst_state", 32'(current_state), 32'h0);
        @(negedge clk) reset = 1'b0;
        in_game_status = 2'b00;
        over_cycles = 0;
      end
    end

    compare_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/connect4_colsel_fsm.md
Name: connect4_colsel_fsm

Overview:
- Column-selection and piece-drop controller for a 4x4 Connect-4 game.
- Accepts a column request from the player input logic and validates it.
- Drops the current player's piece into the lowest empty cell of that column, then alternates turns.
- Exports board occupancy and ownership to the win checker and display; takes game status back from the win checker.

Parameters:
- None. Fixed localparams: ROWS=4, COLS=4, NO_COL=3'b111.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_column  in  3  requested column 0..3; 3'b111 = no request; 4..6 = invalid
- in_game_status  in  2  from win checker: 00 playing, 01 P1 wins, 10 P2 wins, 11 draw
- out_gameboard  out  16  occupancy; bit r*4+c set = cell (row r, col c) filled; row 0 = bottom
- out_players_cells  out  16  owner per cell: 1 = P2, 0 = P1 or empty
- out_game_status  out  2  registered game status
- current_state  out  2  FSM state code
- throw_again  out  1  last request rejected; same player must choose again
- oinvalid_column  out  1  one-cycle pulse on rejection
- playerTurn  out  1  0 = P1 to move, 1 = P2 to move

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, state WAIT, internal armed flag = 1, col_reg = 0.
- States:
  - WAIT = 00
  - CHECK = 01
  - PLACE = 10
  - OVER = 11
- out_game_status: each clock loads in_game_status, except in OVER where it holds.
- WAIT:
  - If in_game_status != 00: go to OVER.
  - Else if armed and in_column != 111: latch col_reg = in_column, clear armed, go to CHECK.
- armed is set again on any clock where in_column == 111. One held request therefore produces exactly one drop.
- in_column must be stable across a rising clock edge; sub-cycle pulses are not captured.
- CHECK: reject if col_reg > 3 or the column's top cell (bit 12+col) is occupied.
  - On reject: oinvalid_column = 1 for one cycle, throw_again = 1, playerTurn unchanged, return to WAIT.
  - Else: go to PLACE.
- PLACE:
  - Find the lowest row r with bit r*4+col clear.
  - Set out_gameboard[r*4+col] and set out_players_cells[r*4+col] = playerTurn.
  - Toggle playerTurn, clear throw_again, go to WAIT.
- Latency: request sampled at edge T, board updated at edge T+2, FSM back in WAIT after T+2.
- OVER:
  - Board, turn and status frozen.
  - in_column is ignored.
  - Only reset exits OVER.
- Reset mid-operation (any state): immediate return to reset values; a partial drop is discarded.
- throw_again persists through WAIT/CHECK until a valid PLACE clears it.

Optional Feature:
- CONNECT4_DRAW_DETECT_EN
- Defined: in WAIT, if out_gameboard == 16'hFFFF and in_game_status == 00, set out_game_status = 11 and go to OVER.
- Undefined: game status comes solely from in_game_status. A full board simply rejects every column as invalid.

Decomposition:
- Package connect4_pkg holds:
  - state enum (WAIT/CHECK/PLACE/OVER with the codes above)
  - game-status codes (PLAYING/P1_WIN/P2_WIN/DRAW)
  - NO_COL, ROWS, COLS
- One natural sub-module, connect4_col_height: combinational block giving, for a column, the lowest empty row index and a full flag from out_gameboard.

Test Plan:
- Reset, then P1 requests col 0 (hold one cycle, then 111): after 2 clocks out_gameboard=0x0001, out_players_cells=0x0000, playerTurn=1, current_state=00.
- P2 requests col 0: out_gameboard=0x0011, out_players_cells=0x0010, playerTurn=0. P1 col 2, then P2 col 3: gameboard=0x001D, players=0x0018.
- Request col 5: oinvalid_column pulses 1 cycle, throw_again=1, board and playerTurn unchanged. Next valid request clears throw_again.
- Five successive requests on col 1: first four fill bits 1, 5, 9, 13 with alternating owners; fifth rejected (oinvalid_column pulse).
- in_game_status=01 while in WAIT: current_state=11, out_game_status=01. Later column requests change nothing.
- Hold in_column=000 for 5 cycles: exactly one piece dropped. Assert reset mid-game: all outputs 0 immediately (asynchronous).
